vx_tcu_lsu_agent: RTL

LSU-side responder for the tensor-core-to-LSU request channel. Accepts load/store requests (valid/ready/addr/load) issued by the tensor core unit, forwards them to the LSU memory request port with a sequence tag, and returns one in-order response per request to the TCU: load data for loads, a zero-data acknowledge for stores. Bounds outstanding traffic with a credit counter and flags out-of-order or corrupt memory tags.

---
 rtl/vx_tcu_lsu_agent.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vx_tcu_lsu_agent.sv
// VX tensor-core LSU agent: tags TCU load/store requests toward memory
// and returns in-order responses to the TCU under a credit limit.
`ifndef XLEN
`define XLEN 32
`endif

module vx_tcu_lsu_agent #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PENDING = 4,
    localparam int TAG_WIDTH  = $clog2(MAX_PENDING),
    localparam int CNT_WIDTH  = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  tcu_req_valid,
    output logic                  tcu_req_ready,
    input  logic [`XLEN-1:0]      tcu_req_addr,
    input  logic                  tcu_req_load,
    input  logic [DATA_WIDTH-1:0] tcu_req_data,

    output logic                  tcu_rsp_valid,
    input  logic                  tcu_rsp_ready,
    output logic [DATA_WIDTH-1:0] tcu_rsp_data,
    output logic                  tcu_rsp_load,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [`XLEN-1:0]      mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    output logic [TAG_WIDTH-1:0]  mem_req_tag,

    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]  mem_rsp_tag,

    output logic [CNT_WIDTH-1:0]  pending,
    output logic                  tag_error
);

    localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(MAX_PENDING);

    logic                  req_valid_q;
    logic                  req_rw_q;
    logic [`XLEN-1:0]      req_addr_q;
    logic [DATA_WIDTH-1:0] req_data_q;
    logic [TAG_WIDTH-1:0]  req_tag_q;

    logic [TAG_WIDTH-1:0]   issue_tag_q;
    logic [TAG_WIDTH-1:0]   expect_tag_q;
    logic [MAX_PENDING-1:0] load_tbl_q;

    logic                  rsp_valid_q;
    logic                  rsp_load_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    logic [CNT_WIDTH-1:0]  pending_q;
    logic [CNT_WIDTH-1:0]  pending_d;
    logic                  tag_err_q;

    logic req_fire;
    logic mrsp_fire;
    logic trsp_fire;
    logic exp_load;

    assign tcu_req_ready = (pending_q < MaxCnt)
                         && (!req_valid_q || mem_req_ready);
    assign mem_rsp_ready = !rsp_valid_q || tcu_rsp_ready;

    assign req_fire  = tcu_req_valid && tcu_req_ready;
    assign mrsp_fire = mem_rsp_valid && mem_rsp_ready;
    assign trsp_fire = rsp_valid_q && tcu_rsp_ready;
    assign exp_load  = load_tbl_q[expect_tag_q];

    // Credits cover a request from TCU accept until its response is consumed.
    always_comb begin
        pending_d = pending_q;
        unique case ({req_fire, trsp_fire})
            2'b10:   pending_d = pending_q + CNT_WIDTH'(1);
            2'b01:   pending_d = pending_q - CNT_WIDTH'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid_q  <= 1'b0;
            req_rw_q     <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_tag_q    <= '0;
            issue_tag_q  <= '0;
            expect_tag_q <= '0;
            load_tbl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_load_q   <= 1'b0;
            rsp_data_q   <= '0;
            pending_q    <= '0;
            tag_err_q    <= 1'b0;
        end else begin
            if (req_fire) begin
                req_valid_q <= 1'b1;
                req_rw_q    <= !tcu_req_load;
                req_addr_q  <= tcu_req_addr;
                req_data_q  <= tcu_req_data;
                req_tag_q   <= issue_tag_q;
                issue_tag_q <= issue_tag_q + TAG_WIDTH'(1);
                load_tbl_q[issue_tag_q] <= tcu_req_load;
            end else if (mem_req_ready) begin
                req_valid_q <= 1'b0;
            end

            // Responses follow issue order; the tag is only a sanity check.
            if (mrsp_fire) begin
                rsp_valid_q  <= 1'b1;
                rsp_load_q   <= exp_load;
                rsp_data_q   <= exp_load ? mem_rsp_data : '0;
                expect_tag_q <= expect_tag_q + TAG_WIDTH'(1);
                if (mem_rsp_tag != expect_tag_q) begin
                    tag_err_q <= 1'b1;
                end
            end else if (tcu_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            pending_q <= pending_d;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_rw    = req_rw_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_data  = req_data_q;
    assign mem_req_tag   = req_tag_q;

    assign tcu_rsp_valid = rsp_valid_q;
    assign tcu_rsp_load  = rsp_load_q;
    assign tcu_rsp_data  = rsp_data_q;

    assign pending   = pending_q;
    assign tag_error = tag_err_q;

endmodule
